// File: rtl/mmu_tlb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mmu_tlb_port_arbiter
// Purpose : Round-robin lock arbiter sharing one TLB lookup port between
//           N_REQ translation FSMs. Muxes the owner's lookup fields onto the
//           shared port and revokes ownership after a programmable hold time.
// Revision: 1.0 - initial release
// ============================================================================
module mmu_tlb_port_arbiter #(
  parameter int N_REQ     = 2,
  parameter int ADDR_BITS = 48,
  parameter int PID_BITS  = 6,
  parameter int CNT_BITS  = 16
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [N_REQ-1:0]              lock,
  input  logic [N_REQ-1:0]              unlock,
  output logic [N_REQ-1:0]              grant,
  output logic [$clog2(N_REQ)-1:0]      owner_id,
  input  logic [N_REQ-1:0]              s_valid,
  input  logic [N_REQ*ADDR_BITS-1:0]    s_addr,
  input  logic [N_REQ*PID_BITS-1:0]     s_pid,
  input  logic [N_REQ-1:0]              s_wr,
  output logic                          m_valid,
  output logic [ADDR_BITS-1:0]          m_addr,
  output logic [PID_BITS-1:0]           m_pid,
  output logic                          m_wr,
  input  logic [CNT_BITS-1:0]           max_hold,
  output logic                          timeout,
  output logic [$clog2(N_REQ)-1:0]      timeout_id,
  output logic [15:0]                   timeout_cnt
);

  localparam int ID_W = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    TURN = 2'd2
  } state_t;

  state_t              state, state_n;
  logic [ID_W-1:0]     rr_ptr, rr_n;
  logic [CNT_BITS-1:0] hold_cnt, hold_n;
  logic [N_REQ-1:0]    grant_n;
  logic [ID_W-1:0]     owner_n;
  logic                to_n;
  logic [ID_W-1:0]     to_id_n;
  logic [15:0]         to_cnt_n;

  logic                pick_found;
  logic [ID_W-1:0]     pick_idx;
  logic [ID_W:0]       scan_sum;
  logic [ID_W-1:0]     scan_idx;
  logic                expire;

  // Find the first requesting lock bit scanning upward from rr_ptr, wrapping at N_REQ.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_sum   = '0;
    scan_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (scan_sum >= (ID_W+1)'(N_REQ)) begin
        scan_sum = scan_sum - (ID_W+1)'(N_REQ);
      end
      scan_idx = scan_sum[ID_W-1:0];
      if (!pick_found && lock[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  // Watchdog fires on the last permitted cycle of a tenure; 0 disables it.
  assign expire = (max_hold != '0) && (hold_cnt == (max_hold - CNT_BITS'(1)));

  // Next-state and next-output logic for the ownership FSM.
  always_comb begin
    state_n  = state;
    grant_n  = grant;
    owner_n  = owner_id;
    rr_n     = rr_ptr;
    hold_n   = hold_cnt;
    to_n     = 1'b0;
    to_id_n  = timeout_id;
    to_cnt_n = timeout_cnt;
    case (state)
      IDLE: begin
        if (pick_found) begin
          grant_n = N_REQ'(1) << pick_idx;
          owner_n = pick_idx;
          rr_n    = (pick_idx == ID_W'(N_REQ-1)) ? '0 : pick_idx + ID_W'(1);
          hold_n  = '0;
          state_n = BUSY;
        end
      end
      BUSY: begin
        if (hold_cnt != '1) begin
          hold_n = hold_cnt + CNT_BITS'(1);
        end
        // A release on the expiry cycle wins over the watchdog.
        if (unlock[owner_id]) begin
          grant_n = '0;
          state_n = TURN;
        end else if (expire) begin
          grant_n = '0;
          to_n    = 1'b1;
          to_id_n = owner_id;
          if (timeout_cnt != 16'hFFFF) begin
            to_cnt_n = timeout_cnt + 16'd1;
          end
          state_n = TURN;
        end
      end
      TURN: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state       <= IDLE;
      grant       <= '0;
      owner_id    <= '0;
      rr_ptr      <= '0;
      hold_cnt    <= '0;
      timeout     <= 1'b0;
      timeout_id  <= '0;
      timeout_cnt <= '0;
    end else begin
      state       <= state_n;
      grant       <= grant_n;
      owner_id    <= owner_n;
      rr_ptr      <= rr_n;
      hold_cnt    <= hold_n;
      timeout     <= to_n;
      timeout_id  <= to_id_n;
      timeout_cnt <= to_cnt_n;
    end
  end

  // Shared-port mux: only the owner's lookup reaches the TLB; idle port reads zero.
  always_comb begin
    m_valid = 1'b0;
    m_addr  = '0;
    m_pid   = '0;
    m_wr    = 1'b0;
    if (|grant) begin
      m_valid = s_valid[owner_id];
      m_addr  = s_addr[owner_id*ADDR_BITS +: ADDR_BITS];
      m_pid   = s_pid[owner_id*PID_BITS +: PID_BITS];
      m_wr    = s_wr[owner_id];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mmu_tlb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mmu_tlb_port_arbiter
// Purpose : Directed self-checking bench for mmu_tlb_port_arbiter with a
//           tenure-level reference model checked every cycle.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mmu_tlb_port_arbiter;

  localparam int N  = 2;
  localparam int AB = 48;
  localparam int PB = 6;
  localparam int CB = 16;

  logic           aclk = 1'b0;
  logic           aresetn;
  logic [N-1:0]   lock, unlock;
  logic [N-1:0]   grant;
  logic [0:0]     owner_id;
  logic           m_valid, m_wr;
  logic [AB-1:0]  m_addr;
  logic [PB-1:0]  m_pid;
  logic [CB-1:0]  max_hold;
  logic           timeout;
  logic [0:0]     timeout_id;
  logic [15:0]    timeout_cnt;

  logic [AB-1:0]  addr_a  [N];
  logic [PB-1:0]  pid_a   [N];
  logic           valid_a [N];
  logic           wr_a    [N];
  logic [N-1:0]   s_valid, s_wr;
  logic [N*AB-1:0] s_addr;
  logic [N*PB-1:0] s_pid;

  assign s_addr  = {addr_a[1], addr_a[0]};
  assign s_pid   = {pid_a[1], pid_a[0]};
  assign s_valid = {valid_a[1], valid_a[0]};
  assign s_wr    = {wr_a[1], wr_a[0]};

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  mmu_tlb_port_arbiter #(.N_REQ(N), .ADDR_BITS(AB), .PID_BITS(PB), .CNT_BITS(CB)) dut (
    .aclk(aclk), .aresetn(aresetn), .lock(lock), .unlock(unlock),
    .grant(grant), .owner_id(owner_id),
    .s_valid(s_valid), .s_addr(s_addr), .s_pid(s_pid), .s_wr(s_wr),
    .m_valid(m_valid), .m_addr(m_addr), .m_pid(m_pid), .m_wr(m_wr),
    .max_hold(max_hold), .timeout(timeout), .timeout_id(timeout_id),
    .timeout_cnt(timeout_cnt)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks the owner as an index (-1 = none), tenure length,
  // the dead cycles left before re-arbitration, and the watchdog statistics.
  int m_own, m_held, m_gap, m_ptr, m_to, m_to_id, m_to_cnt;

  always @(posedge aclk) begin
    if (!aresetn) begin
      m_own = -1; m_held = 0; m_gap = 0; m_ptr = 0;
      m_to = 0; m_to_id = 0; m_to_cnt = 0;
    end else begin
      m_to = 0;
      if (m_own >= 0) begin
        if (unlock[m_own]) begin
          m_own = -1; m_gap = 1;
        end else if (max_hold != 0 && m_held == int'(max_hold) - 1) begin
          m_to = 1; m_to_id = m_own;
          if (m_to_cnt < 65535) m_to_cnt++;
          m_own = -1; m_gap = 1;
        end else if (m_held < (1 << CB) - 1) begin
          m_held++;
        end
      end else if (m_gap > 0) begin
        m_gap--;
      end else if (lock != 0) begin
        for (int k = 0; k < N; k++) begin
          int i;
          i = (m_ptr + k) % N;
          if (m_own < 0 && lock[i]) begin
            m_own = i; m_held = 0; m_ptr = (i + 1) % N;
          end
        end
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge aclk) begin
    if (chk_en) begin
      check("grant", grant, (m_own >= 0) ? (64'd1 << m_own) : 64'd0);
      if (m_own >= 0) check("owner_id", owner_id, m_own);
      check("m_valid", m_valid, (m_own >= 0) ? valid_a[m_own] : 1'b0);
      check("m_addr",  m_addr,  (m_own >= 0) ? addr_a[m_own]  : '0);
      check("m_pid",   m_pid,   (m_own >= 0) ? pid_a[m_own]   : '0);
      check("m_wr",    m_wr,    (m_own >= 0) ? wr_a[m_own]    : 1'b0);
      check("timeout", timeout, m_to);
      check("timeout_id", timeout_id, m_to_id);
      check("timeout_cnt", timeout_cnt, m_to_cnt);
    end
  end

  task automatic cyc();
    @(negedge aclk);
    #1;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    cyc();
    check("rst_grant", grant, 0);
    check("rst_owner", owner_id, 0);
    check("rst_timeout", timeout, 0);
    check("rst_timeout_id", timeout_id, 0);
    check("rst_timeout_cnt", timeout_cnt, 0);
    aresetn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    aresetn = 1'b0; lock = '0; unlock = '0; max_hold = '0;
    for (int i = 0; i < N; i++) begin
      addr_a[i] = '0; pid_a[i] = '0; valid_a[i] = 1'b0; wr_a[i] = 1'b0;
    end
    cyc();
    chk_en = 1'b1;
    do_reset();

    // Single tenure with lookup passing through, then a release.
    valid_a[0] = 1'b1; addr_a[0] = 48'h123; lock = 2'b01;
    cyc();
    check("s1_grant", grant, 2'b01);
    check("s1_mvalid", m_valid, 1);
    check("s1_maddr", m_addr, 48'h123);
    lock = 2'b00;
    cyc(); cyc();
    unlock = 2'b01;
    cyc();
    unlock = 2'b00;
    check("s1_release", grant, 2'b00);
    check("s1_mvalid_off", m_valid, 0);
    cyc();
    check("s1_turn", grant, 2'b00);
    cyc();
    check("s1_idle", grant, 2'b00);
    valid_a[0] = 1'b0;

    // Both requesters contend: ownership alternates, 3 cycles release-to-grant.
    do_reset();
    lock = 2'b11;
    cyc();
    for (int k = 0; k < 4; k++) begin
      check("s2_grant", grant, 64'd1 << (k % 2));
      check("s2_owner", owner_id, k % 2);
      cyc(); cyc();
      unlock = 2'(1 << (k % 2));
      cyc();
      unlock = 2'b00;
      check("s2_gap1", grant, 0);
      cyc();
      check("s2_gap2", grant, 0);
      cyc();
    end
    lock = 2'b00; unlock = 2'b01;
    cyc();
    unlock = 2'b00;
    cyc(); cyc();

    // Watchdog revokes a stuck owner after 4 cycles.
    do_reset();
    max_hold = 16'd4; lock = 2'b10;
    cyc();
    check("s3_grant1", grant, 2'b10);
    lock = 2'b11;
    cyc(); cyc(); cyc();
    check("s3_hold4", grant, 2'b10);
    cyc();
    check("s3_revoke", grant, 0);
    check("s3_timeout", timeout, 1);
    check("s3_timeout_id", timeout_id, 1);
    check("s3_timeout_cnt", timeout_cnt, 1);
    cyc();
    check("s3_pulse_end", timeout, 0);
    cyc();
    check("s3_next_grant", grant, 2'b01);
    check("s3_next_owner", owner_id, 0);

    // Release landing on the expiry cycle is a normal release.
    cyc(); cyc(); cyc();
    check("s4_still_owned", grant, 2'b01);
    unlock = 2'b01; lock = 2'b00;
    cyc();
    unlock = 2'b00;
    check("s4_release", grant, 0);
    check("s4_no_timeout", timeout, 0);
    check("s4_cnt_kept", timeout_cnt, 1);
    cyc();
    check("s4_no_timeout2", timeout, 0);

    // Non-owner unlock and lookup are ignored.
    max_hold = '0;
    valid_a[0] = 1'b1; addr_a[0] = 48'h111; pid_a[0] = 6'd5;  wr_a[0] = 1'b0;
    valid_a[1] = 1'b1; addr_a[1] = 48'hABC; pid_a[1] = 6'd9;  wr_a[1] = 1'b1;
    lock = 2'b01;
    cyc();
    check("s5_grant", grant, 2'b01);
    lock = 2'b00; unlock = 2'b10;
    cyc();
    unlock = 2'b00;
    check("s5_kept", grant, 2'b01);
    check("s5_maddr", m_addr, 48'h111);
    check("s5_mpid", m_pid, 6'd5);
    check("s5_mwr", m_wr, 0);
    valid_a[0] = 1'b0;
    cyc();
    check("s5_mvalid_owner", m_valid, 0);

    // Reset mid-tenure clears everything and re-arbitrates from requester 0.
    lock = 2'b11;
    cyc();
    check("s6_pre_cnt", timeout_cnt, 1);
    aresetn = 1'b0;
    cyc();
    check("s6_rst_grant", grant, 0);
    check("s6_rst_cnt", timeout_cnt, 0);
    aresetn = 1'b1;
    cyc();
    check("s6_regrant", grant, 2'b01);
    check("s6_owner", owner_id, 0);
    lock = 2'b00; unlock = 2'b01;
    cyc();
    unlock = 2'b00;
    cyc(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
